// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one external Mux4 among four requesters and
// captures the selected word into a valid/ready output register.
module mux4_rr_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] mux_out,
    output logic [1:0]       choice,
    output logic [3:0]       ack,
    output logic [WIDTH-1:0] out,
    output logic [1:0]       out_src,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [1:0]       last_q, last_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [1:0]       src_q, src_d;
    logic             valid_q, valid_d;

    logic             cap_en;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic             found;

    // Scan from last+1 upward so the previous winner has the lowest priority.
    always_comb begin
        win   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= 4; k++) begin
            idx = last_q + 2'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign cap_en = !rst && (|req) && (!valid_q || out_ready);
    assign choice = rst ? 2'd3 : (cap_en ? win : last_q);
    assign ack    = cap_en ? 4'(4'b0001 << win) : 4'b0000;

    // A capture also covers a drain on the same edge; valid stays set.
    always_comb begin
        last_d  = last_q;
        out_d   = out_q;
        src_d   = src_q;
        valid_d = valid_q;
        if (cap_en) begin
            out_d   = mux_out;
            src_d   = win;
            last_d  = win;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q  <= 2'd3;
            out_q   <= '0;
            src_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            last_q  <= last_d;
            out_q   <= out_d;
            src_q   <= src_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_src   = src_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural round-robin model.
module tb_mux4_rr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] mux_out;
    logic [1:0]  choice;
    logic [3:0]  ack;
    logic [15:0] dout;
    logic [1:0]  out_src;
    logic        out_valid;
    logic        out_ready;

    logic [15:0] din [4];

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int          m_last;
    logic [15:0] m_out;
    int          m_src;
    bit          m_valid;

    mux4_rr_arbiter #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .mux_out   (mux_out),
        .choice    (choice),
        .ack       (ack),
        .out       (dout),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    // External Mux4
    assign mux_out = din[choice];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int model_win(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return last;
    endfunction

    // One clock: check combinational outputs, advance model, check registers.
    task automatic cycle(input string tag);
        bit cap;
        int w;
        int exp_choice;
        logic [3:0] exp_ack;
        #1;
        cap = !rst && (req != 4'b0000) && (!m_valid || out_ready);
        w = model_win(m_last, req);
        exp_ack = cap ? 4'(1 << w) : 4'b0000;
        exp_choice = rst ? 3 : (cap ? w : m_last);
        chk({tag, ".ack"}, 32'(ack), 32'(exp_ack));
        chk({tag, ".choice"}, 32'(choice), 32'(exp_choice));
        @(posedge clk);
        if (rst) begin
            m_last = 3; m_out = '0; m_src = 0; m_valid = 0;
        end else if (cap) begin
            m_out = din[w]; m_src = w; m_last = w; m_valid = 1;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        #1;
        chk({tag, ".out"}, 32'(dout), 32'(m_out));
        chk({tag, ".out_src"}, 32'(out_src), 32'(m_src));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] held;
        m_last = 3; m_out = '0; m_src = 0; m_valid = 0;
        rst = 1'b1; req = 4'b1111; out_ready = 1'b0;
        for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
        @(negedge clk);

        // Reset state
        cycle("rst0");
        cycle("rst1");
        #1;
        chk("reset.ack", 32'(ack), 32'h0);
        chk("reset.choice", 32'(choice), 32'd3);
        chk("reset.out_valid", 32'(out_valid), 32'h0);
        chk("reset.out", 32'(dout), 32'h0);

        // Single requester
        rst = 1'b0; req = 4'b0100; din[2] = 16'hBEEF; out_ready = 1'b1;
        #1;
        chk("single.ack", 32'(ack), 32'b0100);
        chk("single.choice", 32'(choice), 32'd2);
        cycle("single");
        chk("single.out", 32'(dout), 32'hBEEF);
        chk("single.out_src", 32'(out_src), 32'd2);
        chk("single.out_valid", 32'(out_valid), 32'd1);
        req = 4'b0000;
        cycle("single_drain");

        // Round-robin rotation from reset
        rst = 1'b1;
        cycle("rr_rst");
        rst = 1'b0; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("rr.ack", 32'(ack), 32'(1 << (i % 4)));
            cycle("rr");
            chk("rr.out_src", 32'(out_src), 32'(i % 4));
        end

        // Skip and wrap: set last = 2 first
        req = 4'b0100;
        cycle("wrap_pre");
        req = 4'b0101;
        #1;
        chk("wrap.ack0", 32'(ack), 32'b0001);
        cycle("wrap0");
        #1;
        chk("wrap.ack2", 32'(ack), 32'b0100);
        cycle("wrap1");
        req = 4'b0000;
        cycle("wrap_drain");

        // Backpressure
        req = 4'b0001;
        cycle("bp_fill");
        held = dout;
        out_ready = 1'b0; req = 4'b0010; din[1] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp.ack", 32'(ack), 32'h0);
            cycle("bp");
            chk("bp.out_held", 32'(dout), 32'(held));
        end
        out_ready = 1'b1;
        #1;
        chk("bp.release_ack", 32'(ack), 32'b0010);
        cycle("bp_release");
        chk("bp.new_out", 32'(dout), 32'h1234);
        chk("bp.valid", 32'(out_valid), 32'd1);

        // Reset mid-stream
        out_ready = 1'b0; req = 4'b1000; rst = 1'b1;
        #1;
        chk("midrst.ack", 32'(ack), 32'h0);
        chk("midrst.choice", 32'(choice), 32'd3);
        cycle("midrst");
        chk("midrst.valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("midrst.retry_ack", 32'(ack), 32'b1000);
        cycle("midrst_retry");
        chk("midrst.out_src", 32'(out_src), 32'd3);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            req = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) din[i] = 16'($urandom);
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
